axis_width_converter: RTL and testbench

// - Synthesizable AXI-Stream word-width converter: any S_WORDS-wide input bus to any M_WORDS-wide output bus,

---
 rtl/axis_width_converter.sv | 99 +++++++++
 tb/tb_axis_width_converter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_converter.sv
// AXI-Stream word-width converter: S_WORDS-wide input beats repacked into M_WORDS-wide output beats.
// Sparse input keep is compacted; packet boundaries are kept, so no output beat mixes two packets.
module axis_width_converter #(
  parameter int WORD_WIDTH = 16,
  parameter int S_WORDS    = 4,
  parameter int M_WORDS    = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [S_WORDS*WORD_WIDTH-1:0] s_data,
  input  logic [S_WORDS-1:0]            s_keep,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [M_WORDS*WORD_WIDTH-1:0] m_data,
  output logic [M_WORDS-1:0]            m_keep,
  output logic                          m_last
);

  localparam int CAP = S_WORDS + M_WORDS;
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [CW-1:0] M_CNT = CW'(M_WORDS);

  // state | meaning
  // FILL  | collecting words of a packet; full output beats drain as they form
  // FLUSH | packet end seen; input held off until the tail beat (m_last) leaves
  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;

  state_t                state_q;
  logic [WORD_WIDTH-1:0] buf_q [CAP];
  logic [WORD_WIDTH-1:0] buf_d [CAP];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         n_out, shift, base, kept;
  logic [CW-1:0]         prefix [S_WORDS];
  logic                  in_fire, out_fire;

  assign n_out    = (count_q < M_CNT) ? count_q : M_CNT;
  assign m_valid  = (count_q >= M_CNT) || (state_q == FLUSH);
  assign s_ready  = (state_q == FILL) && (count_q <= M_CNT);
  assign m_last   = (state_q == FLUSH) && (count_q <= M_CNT);
  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;

  always_comb begin : out_decode
    m_keep = '0;
    m_data = '0;
    for (int l = 0; l < M_WORDS; l++) begin
      if (CW'(l) < n_out) begin
        m_keep[l] = 1'b1;
        m_data[l*WORD_WIDTH +: WORD_WIDTH] = buf_q[l];
      end
    end
  end

  always_comb begin : next_buf
    shift = out_fire ? n_out : '0;
    base  = count_q - shift;
    kept  = '0;
    for (int l = 0; l < S_WORDS; l++) begin
      prefix[l] = kept;
      kept      = kept + CW'(s_keep[l]);
    end

    for (int i = 0; i < CAP; i++) buf_d[i] = '0;
    for (int s = 0; s <= M_WORDS; s++) begin
      if (shift == CW'(s)) begin
        for (int i = 0; i < CAP - s; i++) buf_d[i] = buf_q[i+s];
      end
    end

    // kept lanes land after the surviving words, in ascending lane order
    if (in_fire) begin
      for (int i = 0; i < CAP; i++) begin
        for (int l = 0; l < S_WORDS; l++) begin
          if (s_keep[l] && (base + prefix[l] == CW'(i)))
            buf_d[i] = s_data[l*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end

    count_d = base + (in_fire ? kept : '0);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= FILL;
      count_q <= '0;
      for (int i = 0; i < CAP; i++) buf_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < CAP; i++) buf_q[i] <= buf_d[i];
      if (out_fire && m_last) state_q <= FILL;
      if (in_fire && s_last)  state_q <= FLUSH;
    end
  end

endmodule

// File: tb/tb_axis_width_converter.sv
// Directed bench for axis_width_converter: a 4->2 downsizer and a 2->4 upsizer instance,
// plus a randomized backpressure run on the downsizer with a word/packet scoreboard.
module tb_axis_width_converter;

  logic aclk;
  logic areset;
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        dn_s_valid, dn_s_ready, dn_s_last, dn_m_valid, dn_m_ready, dn_m_last;
  logic [63:0] dn_s_data;
  logic [3:0]  dn_s_keep;
  logic [31:0] dn_m_data;
  logic [1:0]  dn_m_keep;

  logic        up_s_valid, up_s_ready, up_s_last, up_m_valid, up_m_ready, up_m_last;
  logic [31:0] up_s_data;
  logic [1:0]  up_s_keep;
  logic [63:0] up_m_data;
  logic [3:0]  up_m_keep;

  axis_width_converter #(.WORD_WIDTH(16), .S_WORDS(4), .M_WORDS(2)) u_dn (
    .aclk(aclk), .areset(areset),
    .s_valid(dn_s_valid), .s_ready(dn_s_ready), .s_data(dn_s_data), .s_keep(dn_s_keep), .s_last(dn_s_last),
    .m_valid(dn_m_valid), .m_ready(dn_m_ready), .m_data(dn_m_data), .m_keep(dn_m_keep), .m_last(dn_m_last)
  );

  axis_width_converter #(.WORD_WIDTH(16), .S_WORDS(2), .M_WORDS(4)) u_up (
    .aclk(aclk), .areset(areset),
    .s_valid(up_s_valid), .s_ready(up_s_ready), .s_data(up_s_data), .s_keep(up_s_keep), .s_last(up_s_last),
    .m_valid(up_m_valid), .m_ready(up_m_ready), .m_data(up_m_data), .m_keep(up_m_keep), .m_last(up_m_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic dn_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] k, input logic l);
    chk({tag, "_valid"}, 64'(dn_m_valid), 64'(v));
    chk({tag, "_data"},  64'(dn_m_data),  64'(d));
    chk({tag, "_keep"},  64'(dn_m_keep),  64'(k));
    chk({tag, "_last"},  64'(dn_m_last),  64'(l));
  endtask

  task automatic dn_drive(input logic [63:0] d, input logic [3:0] k, input logic l);
    dn_s_valid = 1'b1;
    dn_s_data  = d;
    dn_s_keep  = k;
    dn_s_last  = l;
  endtask

  logic [63:0] bd [4];
  logic [3:0]  bk [4];
  logic        bl [4];
  int          nb, k;

  int q [$];
  int pkt_end [$];
  int pushed, popped, lasts, rerr, serr, beats, cyc, wid, n, w, e;
  logic        fired, stall_prev, hold_l;
  logic [31:0] hold_d;
  logic [1:0]  hold_k;

  initial begin
    areset = 1'b1;
    dn_s_valid = 1'b0; dn_s_data = '0; dn_s_keep = '0; dn_s_last = 1'b0; dn_m_ready = 1'b0;
    up_s_valid = 1'b0; up_s_data = '0; up_s_keep = '0; up_s_last = 1'b0; up_m_ready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;

    // reset state
    dn_out("rst", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("rst_s_ready", 64'(dn_s_ready), 64'd1);
    chk("rst_up_valid", 64'(up_m_valid), 64'd0);
    chk("rst_up_s_ready", 64'(up_s_ready), 64'd1);

    // full beat downsized into two output beats
    dn_m_ready = 1'b1;
    dn_drive(64'h0003_0002_0001_0000, 4'b1111, 1'b1);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("down0", 1'b1, 32'h0001_0000, 2'b11, 1'b0);
    chk("down0_s_ready", 64'(dn_s_ready), 64'd0);
    @(negedge aclk);
    dn_out("down1", 1'b1, 32'h0003_0002, 2'b11, 1'b1);
    @(negedge aclk);
    chk("down_idle_valid", 64'(dn_m_valid), 64'd0);
    chk("down_idle_s_ready", 64'(dn_s_ready), 64'd1);

    // sparse keep compaction
    dn_drive(64'h000D_000C_000B_000A, 4'b0101, 1'b1);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("sparse", 1'b1, 32'h000C_000A, 2'b11, 1'b1);
    @(negedge aclk);
    chk("sparse_after_valid", 64'(dn_m_valid), 64'd0);

    // null packet
    dn_drive(64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b1);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("null", 1'b1, 32'h0, 2'b00, 1'b1);
    chk("null_s_ready", 64'(dn_s_ready), 64'd0);
    @(negedge aclk);
    chk("null_after_valid", 64'(dn_m_valid), 64'd0);
    chk("null_after_s_ready", 64'(dn_s_ready), 64'd1);

    // stall holds outputs, then simultaneous drain + append
    dn_m_ready = 1'b0;
    dn_drive(64'h0017_0016_0015_0014, 4'b1111, 1'b0);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("stall0", 1'b1, 32'h0015_0014, 2'b11, 1'b0);
    chk("stall_s_ready", 64'(dn_s_ready), 64'd0);
    repeat (3) begin
      @(negedge aclk);
      dn_out("stall_hold", 1'b1, 32'h0015_0014, 2'b11, 1'b0);
    end
    dn_m_ready = 1'b1;
    @(negedge aclk);
    dn_out("stall1", 1'b1, 32'h0017_0016, 2'b11, 1'b0);
    chk("stall1_s_ready", 64'(dn_s_ready), 64'd1);
    dn_drive(64'h0021_0020_001F_001E, 4'b1110, 1'b1);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("both0", 1'b1, 32'h0020_001F, 2'b11, 1'b0);
    @(negedge aclk);
    dn_out("both1", 1'b1, 32'h0000_0021, 2'b01, 1'b1);
    @(negedge aclk);
    chk("both_after_valid", 64'(dn_m_valid), 64'd0);

    // zero-keep beat without last leaves buffer empty
    dn_drive(64'h1234_5678_9ABC_DEF0, 4'b0000, 1'b0);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    chk("zkeep_valid", 64'(dn_m_valid), 64'd0);
    chk("zkeep_s_ready", 64'(dn_s_ready), 64'd1);
    dn_drive(64'h0000_0000_0029_0028, 4'b0011, 1'b1);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("zkeep_next", 1'b1, 32'h0029_0028, 2'b11, 1'b1);
    @(negedge aclk);

    // upsize 2->4: words 0..9 in five beats
    k = 0; nb = 0;
    up_m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (k < 5) begin
        up_s_valid = 1'b1;
        up_s_data  = {16'(2*k+1), 16'(2*k)};
        up_s_keep  = 2'b11;
        up_s_last  = (k == 4);
      end else begin
        up_s_valid = 1'b0;
      end
      if (up_m_valid && nb < 4) begin
        bd[nb] = up_m_data; bk[nb] = up_m_keep; bl[nb] = up_m_last;
        nb++;
      end
      if (up_s_valid && up_s_ready) k++;
      @(negedge aclk);
    end
    up_s_valid = 1'b0;
    chk("up_beats", 64'(nb), 64'd3);
    chk("up0_data", bd[0], 64'h0003_0002_0001_0000);
    chk("up0_keep", 64'(bk[0]), 64'hF);
    chk("up0_last", 64'(bl[0]), 64'd0);
    chk("up1_data", bd[1], 64'h0007_0006_0005_0004);
    chk("up1_last", 64'(bl[1]), 64'd0);
    chk("up2_data", bd[2], 64'h0000_0000_0009_0008);
    chk("up2_keep", 64'(bk[2]), 64'h3);
    chk("up2_last", 64'(bl[2]), 64'd1);

    // reset mid-packet after 3 of 5 beats
    dn_m_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      dn_drive(64'(16'h0060 + 16'(j)), 4'b0001, 1'b0);
      @(negedge aclk);
    end
    dn_s_valid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    dn_out("mrst", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("mrst_s_ready", 64'(dn_s_ready), 64'd1);
    dn_m_ready = 1'b1;
    dn_drive(64'h0035_0034_0033_0032, 4'b1111, 1'b1);
    @(negedge aclk);
    dn_s_valid = 1'b0;
    dn_out("mrst_pkt0", 1'b1, 32'h0033_0032, 2'b11, 1'b0);
    @(negedge aclk);
    dn_out("mrst_pkt1", 1'b1, 32'h0035_0034, 2'b11, 1'b1);
    @(negedge aclk);
    chk("mrst_after_valid", 64'(dn_m_valid), 64'd0);

    // randomized run: 250 beats of 4 word ids, last every 25 beats
    pushed = 0; popped = 0; lasts = 0; rerr = 0; serr = 0; beats = 0; cyc = 0; wid = 0;
    stall_prev = 1'b0; hold_d = '0; hold_k = '0; hold_l = 1'b0;
    dn_m_ready = 1'b0;
    while (cyc < 40000 && !(beats == 250 && !dn_s_valid && lasts == 10 && q.size() == 0)) begin
      if (stall_prev) begin
        if (dn_m_valid !== 1'b1 || dn_m_data !== hold_d || dn_m_keep !== hold_k || dn_m_last !== hold_l)
          serr++;
      end
      if (!dn_s_valid && beats < 250 && $urandom_range(0, 99) < 5) begin
        for (int l = 0; l < 4; l++) dn_s_data[l*16 +: 16] = 16'(wid + l);
        dn_s_keep  = 4'($urandom_range(0, 15));
        dn_s_last  = ((beats + 1) % 25 == 0);
        dn_s_valid = 1'b1;
        wid += 4;
        beats++;
      end
      fired = 1'b0;
      if (dn_s_valid && dn_s_ready) begin
        for (int l = 0; l < 4; l++) begin
          if (dn_s_keep[l]) begin
            q.push_back(wid - 4 + l);
            pushed++;
          end
        end
        if (dn_s_last) pkt_end.push_back(pushed);
        fired = 1'b1;
      end
      dn_m_ready = ($urandom_range(0, 99) < 20);
      if (dn_m_valid && dn_m_ready) begin
        if (dn_m_keep == 2'b10) rerr++;
        n = 32'(dn_m_keep[0]) + 32'(dn_m_keep[1]);
        for (int l = 0; l < 2; l++) begin
          if (l < n) begin
            if (q.size() == 0) rerr++;
            else begin
              w = q.pop_front();
              if (dn_m_data[l*16 +: 16] !== w[15:0]) rerr++;
            end
            popped++;
          end else if (dn_m_data[l*16 +: 16] !== 16'h0) begin
            rerr++;
          end
        end
        if (dn_m_last) begin
          lasts++;
          if (pkt_end.size() == 0) rerr++;
          else begin
            e = pkt_end.pop_front();
            if (e != popped) rerr++;
          end
        end
      end
      stall_prev = dn_m_valid && !dn_m_ready;
      hold_d = dn_m_data; hold_k = dn_m_keep; hold_l = dn_m_last;
      @(negedge aclk);
      cyc++;
      if (fired) dn_s_valid = 1'b0;
    end
    dn_s_valid = 1'b0;
    chk("rnd_in_time", 64'(cyc < 40000), 64'd1);
    chk("rnd_words", 64'(popped), 64'(pushed));
    chk("rnd_lasts", 64'(lasts), 64'd10);
    chk("rnd_order_err", 64'(rerr), 64'd0);
    chk("rnd_stable_err", 64'(serr), 64'd0);
    chk("rnd_queue_left", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
